spiflash_qmodel: RTL and testbench

//  Synthesisable, oversampled SPI flash target, successor to the behavioural flash model.

---
 rtl/spiflash_qmodel.sv | 237 +++++++++++++++++++++++
 tb/tb_spiflash_qmodel.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spiflash_qmodel.sv
// Oversampled SPI flash target: single-lane command/address decode,
// read data served from an external byte memory on 1, 2 or 4 lanes.
module spiflash_qmodel #(
    parameter int          ADDR_BITS    = 24,
    parameter int          DUMMY_CYCLES = 8,
    parameter logic [23:0] JEDEC_ID     = 24'hEF4018,
    parameter bit          PWR_DEFAULT  = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_csb,
    input  logic                 spi_clk,
    input  logic [3:0]           spi_io_in,
    output logic [3:0]           spi_io_out,
    output logic [3:0]           spi_io_oe,
    output logic                 mem_rd,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [7:0]           mem_rdata,
    output logic                 powered_up
);

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_FAST  = 8'h0B;
    localparam logic [7:0] CMD_DUAL  = 8'h3B;
    localparam logic [7:0] CMD_QUAD  = 8'h6B;
    localparam logic [7:0] CMD_ID    = 8'h9F;
    localparam logic [7:0] CMD_WAKE  = 8'hAB;
    localparam logic [7:0] CMD_SLEEP = 8'hB9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_ID,
        ST_IGNORE
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           sclk_sync_q, sclk_sync_d;
    logic [1:0]           csb_sync_q, csb_sync_d;
    logic [1:0]           io0_sync_q, io0_sync_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [ADDR_BITS-2:0] in_sh_q, in_sh_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [7:0]           data_sh_q, data_sh_d;
    logic [23:0]          id_sh_q, id_sh_d;
    logic                 load_pend_q, load_pend_d;
    logic                 mem_rd_q, mem_rd_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]           io_out_q, io_out_d;
    logic [3:0]           io_oe_q, io_oe_d;
    logic                 pwr_q, pwr_d;

    logic                 csb_s, io0_s, sclk_rise, sclk_fall;
    logic [7:0]           cmd_w, byte_src;
    logic [15:0]          lane_n, cnt_nx;
    logic                 unused_io;

    assign csb_s     = csb_sync_q[1];
    assign io0_s     = io0_sync_q[1];
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cmd_w     = {in_sh_q[6:0], io0_s};
    assign unused_io = ^spi_io_in[3:1];

    // Data fetched this clk is forwarded so a fall edge coinciding with the load still sees it
    assign byte_src  = load_pend_q ? mem_rdata : data_sh_q;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], spi_clk};
        csb_sync_d  = {csb_sync_q[0], spi_csb};
        io0_sync_d  = {io0_sync_q[0], spi_io_in[0]};
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_sh_d     = in_sh_q;
        cmd_d       = cmd_q;
        data_sh_d   = data_sh_q;
        id_sh_d     = id_sh_q;
        load_pend_d = mem_rd_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        io_out_d    = io_out_q;
        io_oe_d     = io_oe_q;
        pwr_d       = pwr_q;
        lane_n      = 16'd1;
        cnt_nx      = cnt_q;

        if (load_pend_q) begin
            data_sh_d = mem_rdata;
        end

        if (csb_s) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            io_out_d = '0;
            io_oe_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        in_sh_d = {in_sh_q[ADDR_BITS-3:0], io0_s};
                        cnt_d   = cnt_q + 16'd1;
                        if (cnt_q == 16'd7) begin
                            cnt_d = '0;
                            cmd_d = cmd_w;
                            case (cmd_w)
                                CMD_WAKE: begin
                                    pwr_d   = 1'b1;
                                    state_d = ST_IGNORE;
                                end
                                CMD_SLEEP: begin
                                    pwr_d   = 1'b0;
                                    state_d = ST_IGNORE;
                                end
                                CMD_READ, CMD_FAST, CMD_DUAL, CMD_QUAD:
                                    state_d = pwr_q ? ST_ADDR : ST_IGNORE;
                                CMD_ID: begin
                                    id_sh_d = JEDEC_ID;
                                    state_d = ST_ID;
                                end
                                default: state_d = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        in_sh_d = {in_sh_q[ADDR_BITS-3:0], io0_s};
                        cnt_d   = cnt_q + 16'd1;
                        if (cnt_q == 16'(ADDR_BITS - 1)) begin
                            cnt_d      = '0;
                            mem_rd_d   = 1'b1;
                            mem_addr_d = {in_sh_q, io0_s};
                            state_d    = (cmd_q == CMD_READ || DUMMY_CYCLES == 0) ? ST_DATA : ST_DUMMY;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (sclk_rise) begin
                        cnt_d = cnt_q + 16'd1;
                        if (cnt_q == 16'(DUMMY_CYCLES - 1)) begin
                            cnt_d   = '0;
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_fall) begin
                        case (cmd_q)
                            CMD_DUAL: begin
                                lane_n   = 16'd2;
                                io_out_d = {2'b00, byte_src[7:6]};
                                io_oe_d  = 4'b0011;
                            end
                            CMD_QUAD: begin
                                lane_n   = 16'd4;
                                io_out_d = byte_src[7:4];
                                io_oe_d  = 4'b1111;
                            end
                            default: begin
                                lane_n   = 16'd1;
                                io_out_d = {2'b00, byte_src[7], 1'b0};
                                io_oe_d  = 4'b0010;
                            end
                        endcase
                        data_sh_d = byte_src << lane_n;
                        cnt_nx    = cnt_q + lane_n;
                        cnt_d     = cnt_nx;
                        // Next byte is requested on its predecessor's last edge to leave fetch margin
                        if (cnt_nx == 16'd8) begin
                            cnt_d      = '0;
                            mem_rd_d   = 1'b1;
                            mem_addr_d = mem_addr_q + ADDR_BITS'(1);
                        end
                    end
                end
                ST_ID: begin
                    if (sclk_fall) begin
                        io_out_d = {2'b00, id_sh_q[23], 1'b0};
                        io_oe_d  = 4'b0010;
                        id_sh_d  = {id_sh_q[22:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sclk_sync_q <= '0;
            csb_sync_q  <= '1;
            io0_sync_q  <= '0;
            cnt_q       <= '0;
            in_sh_q     <= '0;
            cmd_q       <= '0;
            data_sh_q   <= '0;
            id_sh_q     <= '0;
            load_pend_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            io_out_q    <= '0;
            io_oe_q     <= '0;
            pwr_q       <= PWR_DEFAULT;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            csb_sync_q  <= csb_sync_d;
            io0_sync_q  <= io0_sync_d;
            cnt_q       <= cnt_d;
            in_sh_q     <= in_sh_d;
            cmd_q       <= cmd_d;
            data_sh_q   <= data_sh_d;
            id_sh_q     <= id_sh_d;
            load_pend_q <= load_pend_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            io_out_q    <= io_out_d;
            io_oe_q     <= io_oe_d;
            pwr_q       <= pwr_d;
        end
    end

    assign spi_io_out = io_out_q;
    assign spi_io_oe  = io_oe_q;
    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign powered_up = pwr_q;

endmodule

// File: tb/tb_spiflash_qmodel.sv
// Bench for spiflash_qmodel: SPI master tasks, byte memory model and
// expected-value queues filled as each transfer is issued.
module tb_spiflash_qmodel;

    localparam int H = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_csb;
    logic        spi_clk;
    logic [3:0]  spi_io_in;
    logic [3:0]  spi_io_out;
    logic [3:0]  spi_io_oe;
    logic        mem_rd;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        powered_up;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          rd_base;
    logic [7:0]  mem [logic [23:0]];
    logic [23:0] rd_log[$];
    logic [7:0]  exp_q[$];
    logic [23:0] exp_addr_q[$];
    logic [3:0]  oe_acc;

    spiflash_qmodel #(
        .ADDR_BITS   (24),
        .DUMMY_CYCLES(8),
        .JEDEC_ID    (24'hEF4018),
        .PWR_DEFAULT (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_csb   (spi_csb),
        .spi_clk   (spi_clk),
        .spi_io_in (spi_io_in),
        .spi_io_out(spi_io_out),
        .spi_io_oe (spi_io_oe),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .powered_up(powered_up)
    );

    always #5 clk = ~clk;

    // Memory answers one clk after the strobe; every strobe address is logged
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
            rd_log.push_back(mem_addr);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_cycle(input logic mosi, output logic [3:0] io, output logic [3:0] oe);
        spi_io_in = {3'b000, mosi};
        tick(H);
        io = spi_io_out;
        oe = spi_io_oe;
        oe_acc |= spi_io_oe;
        spi_clk = 1'b1;
        tick(H);
        oe_acc |= spi_io_oe;
        spi_clk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        logic [3:0] io, oe;
        for (int i = n - 1; i >= 0; i--) spi_cycle(v[i], io, oe);
    endtask

    task automatic spi_start();
        spi_csb = 1'b0;
        tick(H);
    endtask

    task automatic spi_end();
        spi_csb   = 1'b1;
        spi_io_in = '0;
        tick(2 * H);
    endtask

    task automatic test_reset();
        reset = 1'b1; spi_csb = 1'b1; spi_clk = 1'b0; spi_io_in = '0;
        tick(3);
        n_cmp++;
        if ({spi_io_out, spi_io_oe, mem_rd, mem_addr, powered_up} !== 34'h0) begin
            n_bad++;
            $display("FAIL reset_state: out=%h oe=%h rd=%b addr=%h pwr=%b required all 0",
                     spi_io_out, spi_io_oe, mem_rd, mem_addr, powered_up);
        end
        reset = 1'b0;
        tick(3);
    endtask

    task automatic test_wake();
        logic [3:0] io, oe;
        logic [7:0] b, e;
        logic [23:0] a;
        spi_start(); send_bits(32'hAB, 8); spi_end();
        n_cmp++;
        if (powered_up !== 1'b1) begin
            n_bad++; $display("FAIL wake_pwr: got %b required 1", powered_up);
        end
        mem[24'h10] = 8'hA5; mem[24'h11] = 8'h3C; mem[24'h12] = 8'h7E;
        rd_base = rd_log.size();
        spi_start(); send_bits(32'h03, 8); send_bits(32'h000010, 24);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C); exp_q.push_back(8'h7E);
        for (int k = 0; k < 4; k++) exp_addr_q.push_back(24'h10 + 24'(k));
        for (int by = 0; by < 3; by++) begin
            b = '0;
            for (int i = 0; i < 8; i++) begin
                spi_cycle(1'b0, io, oe);
                b = {b[6:0], io[1]};
                if (i == 0) begin
                    n_cmp++;
                    if (oe !== 4'b0010) begin
                        n_bad++; $display("FAIL read1_oe: got %h required 2", oe);
                    end
                end
            end
            e = exp_q.pop_front();
            n_cmp++;
            if (b !== e) begin
                n_bad++; $display("FAIL read1_byte%0d: got %h required %h", by, b, e);
            end
        end
        spi_end();
        while (exp_addr_q.size() > 0) begin
            a = exp_addr_q.pop_front();
            n_cmp++;
            if (rd_base >= rd_log.size()) begin
                n_bad++; $display("FAIL read1_addr: got none required %h", a);
            end else if (rd_log[rd_base] !== a) begin
                n_bad++; $display("FAIL read1_addr: got %h required %h", rd_log[rd_base], a);
            end
            rd_base++;
        end
    endtask

    task automatic test_powerdown();
        spi_start(); send_bits(32'hB9, 8); spi_end();
        n_cmp++;
        if (powered_up !== 1'b0) begin
            n_bad++; $display("FAIL sleep_pwr: got %b required 0", powered_up);
        end
        rd_base = rd_log.size();
        oe_acc  = '0;
        spi_start(); send_bits(32'h03, 8); send_bits(32'h000000, 24); send_bits(32'h0, 16); spi_end();
        n_cmp++;
        if (oe_acc !== 4'b0000) begin
            n_bad++; $display("FAIL sleep_oe: got %h required 0", oe_acc);
        end
        n_cmp++;
        if (rd_log.size() != rd_base) begin
            n_bad++; $display("FAIL sleep_memrd: got %0d strobes required 0", rd_log.size() - rd_base);
        end
        spi_start(); send_bits(32'hAB, 8); spi_end();
    endtask

    task automatic test_quad();
        logic [3:0] io, oe;
        logic [7:0] e;
        logic [23:0] a;
        mem[24'hFE] = 8'h12; mem[24'hFF] = 8'h34; mem[24'h100] = 8'h56;
        rd_base = rd_log.size();
        spi_start(); send_bits(32'h6B, 8); send_bits(32'h0000FE, 24); send_bits(32'h0, 8);
        exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h56);
        exp_addr_q.push_back(24'hFE); exp_addr_q.push_back(24'hFF); exp_addr_q.push_back(24'h100);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) e = exp_q.pop_front();
            spi_cycle(1'b0, io, oe);
            n_cmp++;
            if (io !== e[7:4] || oe !== 4'hF) begin
                n_bad++; $display("FAIL quad_nib%0d: got io=%h oe=%h required io=%h oe=f", i, io, oe, e[7:4]);
            end
            e = e << 4;
        end
        spi_end();
        while (exp_addr_q.size() > 0) begin
            a = exp_addr_q.pop_front();
            n_cmp++;
            if (rd_base >= rd_log.size() || rd_log[rd_base] !== a) begin
                n_bad++; $display("FAIL quad_addr: got %h required %h",
                                  (rd_base < rd_log.size()) ? rd_log[rd_base] : 24'hxxxxxx, a);
            end
            rd_base++;
        end
    endtask

    task automatic test_dual_wrap();
        logic [3:0] io, oe;
        logic [7:0] e;
        logic [23:0] a;
        mem[24'hFFFFFF] = 8'hC3; mem[24'h000000] = 8'h81;
        rd_base = rd_log.size();
        spi_start(); send_bits(32'h3B, 8); send_bits(32'hFFFFFF, 24); send_bits(32'h0, 8);
        exp_q.push_back(8'hC3); exp_q.push_back(8'h81);
        exp_addr_q.push_back(24'hFFFFFF); exp_addr_q.push_back(24'h000000);
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 0) e = exp_q.pop_front();
            spi_cycle(1'b0, io, oe);
            n_cmp++;
            if (io !== {2'b00, e[7:6]} || oe !== 4'b0011) begin
                n_bad++; $display("FAIL dual_pair%0d: got io=%h oe=%h required io=%h oe=3", i, io, oe, e[7:6]);
            end
            e = e << 2;
        end
        spi_end();
        while (exp_addr_q.size() > 0) begin
            a = exp_addr_q.pop_front();
            n_cmp++;
            if (rd_base >= rd_log.size() || rd_log[rd_base] !== a) begin
                n_bad++; $display("FAIL dual_addr: got %h required %h",
                                  (rd_base < rd_log.size()) ? rd_log[rd_base] : 24'hxxxxxx, a);
            end
            rd_base++;
        end
    endtask

    task automatic test_id();
        logic [3:0] io, oe;
        logic [7:0] b, e;
        spi_start(); send_bits(32'hB9, 8); spi_end();
        spi_start(); send_bits(32'h9F, 8);
        exp_q.push_back(8'hEF); exp_q.push_back(8'h40); exp_q.push_back(8'h18); exp_q.push_back(8'h00);
        for (int by = 0; by < 4; by++) begin
            b = '0;
            for (int i = 0; i < 8; i++) begin
                spi_cycle(1'b0, io, oe);
                b = {b[6:0], io[1]};
            end
            e = exp_q.pop_front();
            n_cmp++;
            if (b !== e || oe !== 4'b0010) begin
                n_bad++; $display("FAIL id_byte%0d: got %h oe=%h required %h oe=2", by, b, oe, e);
            end
        end
        spi_end();
        n_cmp++;
        if (powered_up !== 1'b0) begin
            n_bad++; $display("FAIL id_pwr: got %b required 0", powered_up);
        end
        spi_start(); send_bits(32'hAB, 8); spi_end();
    endtask

    task automatic test_abort();
        logic [3:0] io, oe;
        logic [7:0] b, e;
        mem[24'h30] = 8'h5A; mem[24'h31] = 8'hC6; mem[24'h20] = 8'h96;
        spi_start(); send_bits(32'h03, 8); send_bits(32'h000030, 24);
        exp_q.push_back(8'h5A); exp_q.push_back(8'hC6);
        b = '0;
        for (int i = 0; i < 11; i++) begin
            spi_cycle(1'b0, io, oe);
            b = {b[6:0], io[1]};
            if (i == 7) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (b !== e) begin
                    n_bad++; $display("FAIL abort_byte0: got %h required %h", b, e);
                end
            end
        end
        tick(H);
        b = {b[6:0], spi_io_out[1]};
        e = exp_q.pop_front();
        n_cmp++;
        if (b[3:0] !== e[7:4]) begin
            n_bad++; $display("FAIL abort_nibble: got %h required %h", b[3:0], e[7:4]);
        end
        spi_csb = 1'b1;
        spi_io_in = '0;
        tick(3);
        n_cmp++;
        if (spi_io_oe !== 4'b0000 || spi_io_out !== 4'b0000) begin
            n_bad++; $display("FAIL abort_oe: got oe=%h out=%h required 0 0", spi_io_oe, spi_io_out);
        end
        tick(2 * H);
        spi_start(); send_bits(32'h0B, 8); send_bits(32'h000020, 24); send_bits(32'h0, 8);
        exp_q.push_back(8'h96);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            spi_cycle(1'b0, io, oe);
            b = {b[6:0], io[1]};
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (b !== e) begin
            n_bad++; $display("FAIL fast_after_abort: got %h required %h", b, e);
        end
        spi_end();
    endtask

    task automatic test_reset_mid();
        logic [3:0] io, oe;
        mem[24'h40] = 8'hFF;
        spi_start(); send_bits(32'h03, 8); send_bits(32'h000040, 24);
        for (int i = 0; i < 4; i++) spi_cycle(1'b0, io, oe);
        n_cmp++;
        if (spi_io_oe !== 4'b0010) begin
            n_bad++; $display("FAIL mid_pre_oe: got %h required 2", spi_io_oe);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({spi_io_out, spi_io_oe, mem_rd, mem_addr, powered_up} !== 34'h0) begin
            n_bad++;
            $display("FAIL mid_reset: out=%h oe=%h rd=%b addr=%h pwr=%b required all 0",
                     spi_io_out, spi_io_oe, mem_rd, mem_addr, powered_up);
        end
        spi_csb = 1'b1; spi_clk = 1'b0; spi_io_in = '0;
        tick(2);
        reset = 1'b0;
        tick(3);
    endtask

    initial begin
        oe_acc = '0;
        test_reset();
        test_wake();
        test_powerdown();
        test_quad();
        test_dual_wrap();
        test_id();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
